// File: rtl/nmr_voter_pkg.sv
// Shared health-state encoding, popcount and parameter legality helpers for the NMR voter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package nmr_voter_pkg;

    typedef enum logic [1:0] {
        HS_OK      = 2'b00,
        HS_SUSPECT = 2'b01,
        HS_FAILED  = 2'b10
    } health_t;

    localparam int unsigned MAX_N      = 7;
    localparam int unsigned MAX_THRESH = 15;

    function automatic logic [3:0] popcount(input logic [MAX_N-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < MAX_N; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    function automatic bit params_ok(input int n, input int w, input int thresh);
        return (n % 2 == 1) && (n >= 3) && (n <= MAX_N) && (w >= 1) &&
               (thresh >= 1) && (thresh <= MAX_THRESH);
    endfunction

endpackage

// File: rtl/nmr_voter_seq_if.sv
// Sample/result bundle between the replicated lanes and the voter.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must accept one result per valid sample.
interface nmr_voter_seq_if #(
    parameter int N = 3,
    parameter int W = 8
);
    logic           valid_in;
    logic [N*W-1:0] data_in;
    logic           clear_faults;
    logic           valid_out;
    logic [W-1:0]   data_out;
    logic [N-1:0]   disagree;
    logic           tie;
    logic [N-1:0]   failed;
    logic           all_failed;

    modport master (
        output valid_in, data_in, clear_faults,
        input  valid_out, data_out, disagree, tie, failed, all_failed
    );

    modport slave (
        input  valid_in, data_in, clear_faults,
        output valid_out, data_out, disagree, tie, failed, all_failed
    );
endinterface

// File: rtl/voter_channel_health.sv
// Per-channel health tracker: OK -> SUSPECT -> FAILED on consecutive disagreements.
// Latency: state updates at the edge after the qualifying sample.
// Backpressure: none; advances only on valid samples, clear wins over updates.
module voter_channel_health
    import nmr_voter_pkg::*;
#(
    parameter int FAIL_THRESH = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    valid,
    input  logic    disagree,
    input  logic    clear,
    output logic    failed,
    output health_t state
);
    localparam int CW = $clog2(FAIL_THRESH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FAIL_THRESH - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FAIL_THRESH);

    health_t       state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HS_OK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (clear) begin
            state_nxt = HS_OK;
            cnt_nxt   = '0;
        end else if (valid) begin
            case (state)
                HS_OK: begin
                    if (disagree) begin
                        cnt_nxt   = CNT_ONE;
                        state_nxt = (FAIL_THRESH == 1) ? HS_FAILED : HS_SUSPECT;
                    end
                end
                HS_SUSPECT: begin
                    if (!disagree) begin
                        cnt_nxt   = '0;
                        state_nxt = HS_OK;
                    end else if (cnt >= CNT_LAST) begin
                        // Counter pins at the threshold once the channel fails.
                        cnt_nxt   = CNT_MAX;
                        state_nxt = HS_FAILED;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                HS_FAILED: begin
                    state_nxt = HS_FAILED;
                end
                default: begin
                    state_nxt = HS_OK;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign failed = (state == HS_FAILED);

endmodule

// File: rtl/nmr_voter_seq.sv
// Registered N-way bitwise majority voter with per-channel fault exclusion.
// Latency: 1 cycle from valid_in to valid_out; outputs hold while idle.
// Backpressure: none; every valid sample yields exactly one result pulse.
module nmr_voter_seq
    import nmr_voter_pkg::*;
#(
    parameter int N           = 3,
    parameter int W           = 8,
    parameter int FAIL_THRESH = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    nmr_voter_seq_if.slave bus
);
    if (!params_ok(N, W, FAIL_THRESH)) begin : g_param_err
        $error("nmr_voter_seq: N must be odd in 3..7 and FAIL_THRESH in 1..15");
    end

    logic [N-1:0]       failed_mask;
    logic [N-1:0]       active;
    logic [N-1:0]       chan_is_failed;
    health_t            chan_state [N];
    logic [MAX_N-1:0]   act_pad;
    logic [MAX_N-1:0]   col;
    logic [3:0]         act_cnt;
    logic [3:0]         ones;
    logic [W-1:0]       vote_c;
    logic               tie_c;
    logic [N-1:0]       dis_c;

    assign active = ~failed_mask;

    // Majority per bit over the active set only; an even split resolves to 0 and flags a tie.
    always_comb begin
        act_pad = '0;
        col     = '0;
        ones    = '0;
        vote_c  = '0;
        tie_c   = 1'b0;
        dis_c   = '0;
        act_pad[N-1:0] = active;
        act_cnt = popcount(act_pad);
        for (int i = 0; i < W; i++) begin
            col = '0;
            for (int k = 0; k < N; k++) begin
                col[k] = bus.data_in[k*W+i] & active[k];
            end
            ones = popcount(col);
            if ({ones, 1'b0} > {1'b0, act_cnt}) begin
                vote_c[i] = 1'b1;
            end else if ({ones, 1'b0} == {1'b0, act_cnt}) begin
                tie_c = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            dis_c[k] = (bus.data_in[k*W +: W] != vote_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_out <= 1'b0;
            bus.data_out  <= '0;
            bus.disagree  <= '0;
            bus.tie       <= 1'b0;
        end else begin
            bus.valid_out <= bus.valid_in;
            if (bus.valid_in) begin
                bus.data_out <= vote_c;
                bus.disagree <= dis_c;
                bus.tie      <= tie_c;
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_health
        voter_channel_health #(
            .FAIL_THRESH (FAIL_THRESH)
        ) u_health (
            .clk      (clk),
            .rst_n    (rst_n),
            .valid    (bus.valid_in),
            .disagree (dis_c[k]),
            .clear    (bus.clear_faults),
            .failed   (failed_mask[k]),
            .state    (chan_state[k])
        );
        assign chan_is_failed[k] = (chan_state[k] == HS_FAILED);
    end

    assign bus.failed     = failed_mask;
    assign bus.all_failed = &chan_is_failed;

endmodule

// File: tb/tb_nmr_voter_seq.sv
// Self-checking bench for nmr_voter_seq: directed scenarios plus random samples on N=3 and N=5
// instances, compared against a counting-based reference model of the voting and health rules.
module tb_nmr_voter_seq;
    localparam int THR = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nmr_voter_seq_if #(.N(3), .W(8)) bus3 ();
    nmr_voter_seq_if #(.N(5), .W(8)) bus5 ();

    nmr_voter_seq #(.N(3), .W(8), .FAIL_THRESH(THR)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    nmr_voter_seq #(.N(5), .W(8), .FAIL_THRESH(THR)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, indexed [dut][channel]
    bit         mfail [2][7];
    int         mcnt  [2][7];
    bit         e_vld [2];
    logic [7:0] e_data[2];
    logic [6:0] e_dis [2];
    bit         e_tie [2];
    int         nch   [2] = '{3, 5};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] p3(input logic [7:0] c0, c1, c2);
        return {32'h0, c2, c1, c0};
    endfunction

    function automatic logic [55:0] p5(input logic [7:0] c0, c1, c2, c3, c4);
        return {16'h0, c4, c3, c2, c1, c0};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 7; k++) begin
                mfail[d][k] = 1'b0;
                mcnt[d][k]  = 0;
            end
            e_vld[d]  = 1'b0;
            e_data[d] = '0;
            e_dis[d]  = '0;
            e_tie[d]  = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input logic [55:0] data, input bit v, input bit clr);
        int         a;
        int         ones;
        logic [7:0] vw;
        logic [7:0] wk;
        logic [6:0] dis;
        bit         tie;
        dis = '0;
        e_vld[d] = v;
        if (v) begin
            a = 0;
            for (int k = 0; k < nch[d]; k++) if (!mfail[d][k]) a++;
            vw  = '0;
            tie = 1'b0;
            for (int i = 0; i < 8; i++) begin
                ones = 0;
                for (int k = 0; k < nch[d]; k++)
                    if (!mfail[d][k] && data[k*8+i]) ones++;
                if (2 * ones > a) vw[i] = 1'b1;
                else if (2 * ones == a) tie = 1'b1;
            end
            for (int k = 0; k < nch[d]; k++) begin
                wk = data[k*8 +: 8];
                dis[k] = (wk != vw);
            end
            e_data[d] = vw;
            e_dis[d]  = dis;
            e_tie[d]  = tie;
        end
        if (clr) begin
            for (int k = 0; k < 7; k++) begin
                mfail[d][k] = 1'b0;
                mcnt[d][k]  = 0;
            end
        end else if (v) begin
            for (int k = 0; k < nch[d]; k++) begin
                if (!mfail[d][k]) begin
                    if (dis[k]) begin
                        mcnt[d][k]++;
                        if (mcnt[d][k] >= THR) mfail[d][k] = 1'b1;
                    end else begin
                        mcnt[d][k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_dut(input int d, input string tag);
        logic [6:0] efail;
        bit         eall;
        efail = '0;
        eall  = 1'b1;
        for (int k = 0; k < nch[d]; k++) begin
            efail[k] = mfail[d][k];
            if (!mfail[d][k]) eall = 1'b0;
        end
        if (d == 0) begin
            chk($sformatf("%s.valid_out", tag),  bus3.valid_out,  e_vld[0]);
            chk($sformatf("%s.data_out", tag),   bus3.data_out,   e_data[0]);
            chk($sformatf("%s.disagree", tag),   bus3.disagree,   e_dis[0][2:0]);
            chk($sformatf("%s.tie", tag),        bus3.tie,        e_tie[0]);
            chk($sformatf("%s.failed", tag),     bus3.failed,     efail[2:0]);
            chk($sformatf("%s.all_failed", tag), bus3.all_failed, eall);
        end else begin
            chk($sformatf("%s.valid_out", tag),  bus5.valid_out,  e_vld[1]);
            chk($sformatf("%s.data_out", tag),   bus5.data_out,   e_data[1]);
            chk($sformatf("%s.disagree", tag),   bus5.disagree,   e_dis[1][4:0]);
            chk($sformatf("%s.tie", tag),        bus5.tie,        e_tie[1]);
            chk($sformatf("%s.failed", tag),     bus5.failed,     efail[4:0]);
            chk($sformatf("%s.all_failed", tag), bus5.all_failed, eall);
        end
    endtask

    task automatic step(input int d, input logic [55:0] data, input bit v, input bit clr,
                        input string tag);
        @(negedge clk);
        if (d == 0) begin
            bus3.valid_in     = v;
            bus3.data_in      = data[23:0];
            bus3.clear_faults = clr;
        end else begin
            bus5.valid_in     = v;
            bus5.data_in      = data[39:0];
            bus5.clear_faults = clr;
        end
        model_step(d, data, v, clr);
        @(posedge clk);
        #1;
        check_dut(d, tag);
        bus3.valid_in     = 1'b0;
        bus3.clear_faults = 1'b0;
        bus5.valid_in     = 1'b0;
        bus5.clear_faults = 1'b0;
    endtask

    task automatic rand_steps(input int d, input int count);
        logic [7:0]  base;
        logic [55:0] data;
        bit          v;
        bit          clr;
        for (int n = 0; n < count; n++) begin
            base = 8'($urandom);
            data = '0;
            for (int k = 0; k < nch[d]; k++)
                data[k*8 +: 8] = ($urandom_range(3) == 0) ? 8'($urandom) : base;
            v   = ($urandom_range(3) != 0);
            clr = ($urandom_range(29) == 0);
            step(d, data, v, clr, (d == 0) ? "rand3" : "rand5");
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus3.valid_in     = 1'b0;
        bus3.data_in      = '0;
        bus3.clear_faults = 1'b0;
        bus5.valid_in     = 1'b0;
        bus5.data_in      = '0;
        bus5.clear_faults = 1'b0;
        model_reset();
        #12;
        check_dut(0, "reset3");
        check_dut(1, "reset5");
        @(negedge clk);
        rst_n = 1'b1;

        step(0, p3(8'hA5, 8'hA5, 8'hA5), 1, 0, "all_a5");
        chk("all_a5.const", bus3.data_out, 8'hA5);
        step(0, p3(8'hA5, 8'hA4, 8'hA5), 1, 0, "upset");
        chk("upset.const", bus3.disagree, 3'b010);
        step(0, '0, 0, 0, "hold");

        repeat (THR) step(0, p3(8'hFF, 8'h00, 8'hFF), 1, 0, "persist");
        chk("persist.const", bus3.failed, 3'b010);
        step(0, p3(8'hFF, 8'h00, 8'h0F), 1, 0, "tie_a2");
        chk("tie_a2.data", bus3.data_out, 8'h0F);
        chk("tie_a2.tie", bus3.tie, 1'b1);

        step(0, p3(8'hFF, 8'h00, 8'h0F), 1, 1, "clear_vote");
        chk("clear_vote.const", bus3.failed, 3'b000);
        step(0, p3(8'hFF, 8'hFF, 8'h0F), 1, 0, "post_clear");
        chk("post_clear.const", bus3.data_out, 8'hFF);

        repeat (2) step(0, p3(8'h55, 8'hAA, 8'h55), 1, 0, "rec_dis");
        step(0, p3(8'h55, 8'h55, 8'h55), 1, 0, "rec_agree");
        repeat (2) step(0, p3(8'h55, 8'hAA, 8'h55), 1, 0, "rec_dis2");
        chk("recovery.const", bus3.failed, 3'b000);

        repeat (2) step(0, p3(8'h33, 8'h33, 8'hCC), 1, 0, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_dut(0, "async_rst3");
        check_dut(1, "async_rst5");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (THR - 1) step(0, p3(8'h33, 8'h33, 8'hCC), 1, 0, "post_rst");
        chk("post_rst.const", bus3.failed, 3'b000);
        step(0, p3(8'h33, 8'h33, 8'hCC), 1, 0, "post_rst_fail");
        chk("post_rst_fail.const", bus3.failed, 3'b100);
        step(0, '0, 0, 1, "clear_idle");

        repeat (THR) step(0, p3(8'hFF, 8'h00, 8'hFF), 1, 0, "af_ch1");
        repeat (THR) step(0, p3(8'hF0, 8'h00, 8'h0F), 1, 0, "af_split");
        chk("all_failed.const", bus3.all_failed, 1'b1);
        step(0, p3(8'h12, 8'h34, 8'h56), 1, 0, "af_vote");
        chk("af_vote.tie", bus3.tie, 1'b1);
        step(0, '0, 0, 1, "af_clear");

        rand_steps(0, 300);

        repeat (THR) step(1, p5(8'hC3, 8'h3C, 8'hC3, 8'h5A, 8'hC3), 1, 0, "n5_fail");
        chk("n5_fail.const", bus5.failed, 5'b01010);
        step(1, p5(8'h11, 8'h22, 8'h33, 8'h44, 8'h55), 1, 0, "n5_a3");
        chk("n5_a3.const", bus5.data_out, 8'h11);
        rand_steps(1, 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nmr_voter_seq.md
Name: nmr_voter_seq

Overview:
Parametrised, registered N-modular-redundancy bitwise majority voter. It is the sequential successor to the 3-input combinational majority voter. Each channel's agreement with the voted word is tracked over time. A channel that disagrees on FAIL_THRESH consecutive valid samples is excluded from voting until software clears it. The block sits between replicated datapath lanes and the single consumer, and reports channel health to a status register.

Parameters:
N, 3, number of redundant channels; odd, 3..7
W, 8, data width per channel in bits
FAIL_THRESH, 3, consecutive disagreeing valid samples that mark a channel FAILED; 1..15

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  data_in holds a sample this cycle
data_in  in  N*W  channel k occupies bits [k*W+W-1 : k*W]
clear_faults  in  1  one-cycle pulse; returns all channels to OK
valid_out  out  1  data_out and flags are valid (one pulse per sample)
data_out  out  W  voted word
disagree  out  N  channel k differed from data_out on this sample
tie  out  1  at least one bit had no strict majority among active channels
failed  out  N  sticky per-channel FAILED status
all_failed  out  1  no active channels remain

Behaviour:
- Reset (async, rst_n=0): valid_out=0, data_out=0, disagree=0, tie=0, failed=0, all_failed=0. All channel counters are 0 and all states are OK. Release is synchronous to clk.
- Active set A = channels whose failed bit is 0, taken from the registered mask at the start of the cycle. Let a = popcount(A).
- Vote: for each bit i, count the ones across channels in A.
  - Output bit = 1 iff 2*ones > a.
  - If 2*ones == a, the output bit = 0 and tie=1.
  - Odd a never produces a tie.
  - If a=0: data_out=0, tie=1, all_failed=1.
- Latency: exactly 1 cycle. A sample with valid_in=1 at edge t gives valid_out=1 with its results after edge t. While valid_in=0, outputs hold their last values and valid_out=0.
- disagree[k] = (channel k word != voted word) over the full W bits. It is computed for every channel, failed ones included, so software can observe recovery.
- Per-channel health FSM, updated only on valid_in=1:
  - OK: disagree sets cnt=1 and moves to SUSPECT. If FAIL_THRESH=1, it moves straight to FAILED.
  - SUSPECT: disagree increments cnt; when cnt reaches FAIL_THRESH, move to FAILED. Agree clears cnt and returns to OK.
  - FAILED: sticky; cnt is frozen; the channel is excluded from A starting the cycle after entry.
  - failed[k] = (state==FAILED), registered.
- clear_faults: every FSM goes to OK and every cnt to 0 at the next edge.
  - If valid_in=1 in the same cycle, that sample is voted with the pre-clear mask.
  - clear_faults has priority over any health update from that sample.
- Counter width is $clog2(FAIL_THRESH+1). The counter saturates and never wraps.
- Two channels reaching the FAILED threshold on the same sample both fail together. The vote for that sample still uses the old mask.
- all_failed is combinational from the registered failed mask.

Decomposition:
- Package nmr_voter_pkg holds:
  - health state encoding: OK=2'b00, SUSPECT=2'b01, FAILED=2'b10
  - popcount function
  - parameter legality checks (N odd, 3 ≤ N ≤ 7)
- Sub-module voter_channel_health: one per channel via generate. It contains the FSM and saturating counter, with inputs valid, disagree and clear, and outputs failed and state.

Test Plan:
- Reset with N=3, W=8: all outputs are 0. Drive all channels 0xA5 with valid_in=1 -> next cycle data_out=0xA5, valid_out=1, disagree=000, tie=0.
- Single-bit upset: ch0=0xA5, ch1=0xA4, ch2=0xA5 -> data_out=0xA5, disagree=010, failed=000.
- Persistent fault: ch1=0x00 and the others 0xFF for 3 valid samples -> failed[1]=1 after the third. Then ch0=0xFF, ch2=0x0F gives a=2, data_out=0x0F, tie=1.
- Recovery: ch1 disagrees twice, agrees once, then disagrees twice -> failed[1] stays 0, because the counter was cleared by the agreement.
- clear_faults pulse together with a valid sample while ch1 is FAILED -> that sample is voted without ch1. failed=000 at the next edge, and the following sample is voted with all three channels.
- Mid-operation reset: assert rst_n=0 while ch2 is in SUSPECT with cnt=2 -> all outputs go to 0 immediately. After release, ch2 needs 3 fresh disagreements to fail. Also run N=5 with two channels failed: a=3 and voting is correct.
